// File: rtl/apb_slave_if.sv
// apb_slave_if -- APB bus bundle between a master and apb_slave.
//   Psel, Penable, Pwrite, Paddress[3:0], PWdata[K-1:0] : master -> slave
//   PRdata[K-1:0], Pready, Pslverr                      : slave -> master
// Clock and reset are not part of the bundle.
interface apb_slave_if #(
  parameter int K = 8
);
  logic         Psel;
  logic         Penable;
  logic         Pwrite;
  logic [3:0]   Paddress;
  logic [K-1:0] PWdata;
  logic [K-1:0] PRdata;
  logic         Pready;
  logic         Pslverr;

  modport master (
    output Psel, Penable, Pwrite, Paddress, PWdata,
    input  PRdata, Pready, Pslverr
  );

  modport slave (
    input  Psel, Penable, Pwrite, Paddress, PWdata,
    output PRdata, Pready, Pslverr
  );
endinterface

// File: rtl/apb_slave.sv
// apb_slave -- small APB register slave with programmable wait states.
//   PCLK    : clock, all state updates on the rising edge
//   Preset  : asynchronous active-high reset
//   bus     : apb_slave_if.slave (Psel/Penable/Pwrite/Paddress/PWdata in,
//             PRdata/Pready/Pslverr out)
// Address 0 returns the read-only ID; addresses 1..DEPTH-1 are K-bit
// storage; anything at or above DEPTH, or a write to 0, answers with Pslverr.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transfer in flight, outputs held at 0
// ACCESS | transfer captured; cnt counts remaining wait states, done at 0
module apb_slave #(
  parameter int           K     = 8,
  parameter int           WAIT  = 0,
  parameter int           DEPTH = 12,
  parameter logic [K-1:0] ID    = 8'hA5
) (
  input  logic         PCLK,
  input  logic         Preset,
  apb_slave_if.slave   bus
);

  localparam logic [3:0] WAIT_C  = 4'(WAIT);
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   addr_q, addr_d;
  logic         wr_q, wr_d;
  logic [K-1:0] wd_q, wd_d;
  logic         mem_we;
  logic         ready;
  logic         err;
  logic [K-1:0] rdata;

  // Entry 0 is never written, so it stays at its reset value and
  // synthesis folds it away; reads of address 0 are served by ID.
  logic [K-1:0] mem [DEPTH];

  assign ready = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign err   = ({1'b0, addr_q} >= DEPTH_C) || (wr_q && (addr_q == 4'd0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wd_d    = wd_q;
    mem_we  = 1'b0;
    // A setup phase always wins, even in ACCESS, so a master that
    // restarts mid-transfer simply replaces the pending one.
    if (bus.Psel && !bus.Penable) begin
      addr_d  = bus.Paddress;
      wr_d    = bus.Pwrite;
      wd_d    = bus.PWdata;
      cnt_d   = WAIT_C;
      state_d = ACCESS;
    end else if (state_q == ACCESS) begin
      if (!bus.Psel) begin
        state_d = IDLE;
      end else if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = IDLE;
        mem_we  = wr_q && !err;
      end
    end
  end

  always_ff @(posedge PCLK or posedge Preset) begin
    if (Preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wd_q    <= wd_d;
    end
  end

  always_ff @(posedge PCLK or posedge Preset) begin
    if (Preset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[addr_q] <= wd_q;
    end
  end

  always_comb begin
    rdata = '0;
    if (ready && !wr_q && !err) begin
      rdata = (addr_q == 4'd0) ? ID : mem[addr_q];
    end
  end

  assign bus.Pready  = ready;
  assign bus.Pslverr = ready && err;
  assign bus.PRdata  = rdata;

endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave -- scoreboard bench for apb_slave.
// Two instances: dut 0 with no wait states, dut 1 with three.
// Transfers push their expected response when issued; a per-dut monitor
// pops and compares whenever a completing enable cycle is seen.
module tb_apb_slave;

  localparam int         DEPTH = 12;
  localparam logic [7:0] IDV   = 8'hA5;

  typedef struct {
    logic [7:0] rd;
    logic       err;
  } exp_t;

  logic PCLK;
  logic rst_a, rst_b;
  int   n_checks = 0;
  int   n_errors = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       e0, e1;
  logic [7:0] mdl [2][16];

  apb_slave_if #(.K(8)) ifa ();
  apb_slave_if #(.K(8)) ifb ();

  apb_slave #(.K(8), .WAIT(0), .DEPTH(DEPTH), .ID(IDV)) u_a (
    .PCLK(PCLK), .Preset(rst_a), .bus(ifa.slave)
  );
  apb_slave #(.K(8), .WAIT(3), .DEPTH(DEPTH), .ID(IDV)) u_b (
    .PCLK(PCLK), .Preset(rst_b), .bus(ifb.slave)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic rdy(input int d);
    return (d == 0) ? ifa.Pready : ifb.Pready;
  endfunction

  function automatic logic [7:0] rdat(input int d);
    return (d == 0) ? ifa.PRdata : ifb.PRdata;
  endfunction

  function automatic logic serr(input int d);
    return (d == 0) ? ifa.Pslverr : ifb.Pslverr;
  endfunction

  task automatic drive(input int d, input logic s, input logic en, input logic w,
                       input logic [3:0] a, input logic [7:0] wd);
    if (d == 0) begin
      ifa.Psel = s; ifa.Penable = en; ifa.Pwrite = w; ifa.Paddress = a; ifa.PWdata = wd;
    end else begin
      ifb.Psel = s; ifb.Penable = en; ifb.Pwrite = w; ifb.Paddress = a; ifb.PWdata = wd;
    end
  endtask

  task automatic idle(input int d, input int n);
    drive(d, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    repeat (n) begin @(posedge PCLK); #1; end
  endtask

  task automatic clear_model(input int d);
    for (int i = 0; i < 16; i++) mdl[d][i] = 8'd0;
  endtask

  // Setup phase plus the switch to the enable phase. With push set the
  // reference outcome is computed from the address map and queued.
  task automatic begin_xfer(input int d, input bit wr, input logic [3:0] a,
                            input logic [7:0] wd, input bit push);
    exp_t e;
    bit   err;
    err   = (int'(a) >= DEPTH) || (wr && a == 4'd0);
    e.err = err;
    if (wr || err)       e.rd = 8'd0;
    else if (a == 4'd0)  e.rd = IDV;
    else                 e.rd = mdl[d][a];
    if (push) begin
      if (wr && !err) mdl[d][a] = wd;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    drive(d, 1'b1, 1'b0, wr, a, wd);
    @(posedge PCLK); #1;
    drive(d, 1'b1, 1'b1, wr, a, wd);
  endtask

  task automatic xfer(input int d, input bit wr, input logic [3:0] a, input logic [7:0] wd);
    int n;
    bit done;
    begin_xfer(d, wr, a, wd, 1'b1);
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge PCLK);
      n++;
      if (rdy(d) === 1'b1) done = 1'b1;
      @(posedge PCLK); #1;
    end
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL xfer_timeout dut%0d: got no Pready required Pready within 40 cycles", d);
    end else begin
      chk($sformatf("latency_dut%0d", d), n, wait_of(d) + 1);
    end
  endtask

  // Setup, n_wait enable cycles with Pready low, then Psel dropped.
  task automatic abort(input int d, input bit wr, input logic [3:0] a,
                       input logic [7:0] wd, input int n_wait);
    begin_xfer(d, wr, a, wd, 1'b0);
    if (n_wait == 0) drive(d, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < n_wait; i++) begin
      @(negedge PCLK);
      chk($sformatf("abort_wait_ready_dut%0d", d), rdy(d), 1'b0);
      @(posedge PCLK); #1;
    end
    idle(d, 1);
  endtask

  always @(negedge PCLK) begin
    if (ifa.Psel && ifa.Penable && ifa.Pready === 1'b1) begin
      if (q0.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL mon0_unexpected: got Pready=1 required no completion");
      end else begin
        e0 = q0.pop_front();
        chk("mon0_rdata", ifa.PRdata, e0.rd);
        chk("mon0_slverr", ifa.Pslverr, e0.err);
      end
    end else if (ifa.Pready !== 1'b1) begin
      chk("mon0_quiet", {ifa.Pslverr, ifa.PRdata}, 0);
    end
  end

  always @(negedge PCLK) begin
    if (ifb.Psel && ifb.Penable && ifb.Pready === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL mon1_unexpected: got Pready=1 required no completion");
      end else begin
        e1 = q1.pop_front();
        chk("mon1_rdata", ifb.PRdata, e1.rd);
        chk("mon1_slverr", ifb.Pslverr, e1.err);
      end
    end else if (ifb.Pready !== 1'b1) begin
      chk("mon1_quiet", {ifb.Pslverr, ifb.PRdata}, 0);
    end
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    clear_model(0);
    clear_model(1);
    drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    #12;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_ready_dut%0d", d), rdy(d), 1'b0);
      chk($sformatf("reset_rdata_dut%0d", d), rdat(d), 8'd0);
      chk($sformatf("reset_slverr_dut%0d", d), serr(d), 1'b0);
    end
    @(negedge PCLK);
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(posedge PCLK); #1;

    // dut 0, zero wait states
    xfer(0, 1'b1, 4'd5, 8'h3C);
    xfer(0, 1'b0, 4'd5, 8'h00);
    xfer(0, 1'b1, 4'd0, 8'hFF);
    xfer(0, 1'b1, 4'd13, 8'h77);
    xfer(0, 1'b0, 4'd0, 8'h00);
    xfer(0, 1'b0, 4'd5, 8'h00);
    xfer(0, 1'b0, 4'd13, 8'h00);
    xfer(0, 1'b1, 4'd1, 8'h11);
    xfer(0, 1'b1, 4'd2, 8'h22);
    xfer(0, 1'b1, 4'd3, 8'h33);
    xfer(0, 1'b0, 4'd1, 8'h00);
    xfer(0, 1'b0, 4'd2, 8'h00);
    xfer(0, 1'b0, 4'd3, 8'h00);
    idle(0, 1);

    // Penable without a setup phase must not start anything
    drive(0, 1'b0, 1'b1, 1'b1, 4'd5, 8'h99);
    @(negedge PCLK); chk("idle_penable_ready", rdy(0), 1'b0);
    @(posedge PCLK); #1;
    drive(0, 1'b1, 1'b1, 1'b1, 4'd5, 8'h99);
    @(negedge PCLK); chk("idle_sel_penable_ready", rdy(0), 1'b0);
    @(posedge PCLK); #1;
    idle(0, 1);
    xfer(0, 1'b0, 4'd5, 8'h00);

    // reset while a read of address 1 is presenting data
    begin_xfer(0, 1'b0, 4'd1, 8'h00, 1'b1);
    @(negedge PCLK); #2;
    rst_a = 1'b1;
    #1;
    chk("async_rst_ready", rdy(0), 1'b0);
    chk("async_rst_rdata", rdat(0), 8'd0);
    chk("async_rst_slverr", serr(0), 1'b0);
    drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    clear_model(0);
    @(negedge PCLK);
    rst_a = 1'b0;
    @(posedge PCLK); #1;
    xfer(0, 1'b0, 4'd1, 8'h00);
    xfer(0, 1'b0, 4'd5, 8'h00);

    // dut 1, three wait states
    xfer(1, 1'b0, 4'd0, 8'h00);
    abort(1, 1'b1, 4'd7, 8'h7E, 1);
    xfer(1, 1'b0, 4'd7, 8'h00);
    xfer(1, 1'b1, 4'd4, 8'hC4);
    begin_xfer(1, 1'b1, 4'd4, 8'h44, 1'b0);
    @(negedge PCLK);
    chk("rst_wait_ready_before", rdy(1), 1'b0);
    #2;
    rst_b = 1'b1;
    #1;
    chk("rst_wait_ready", rdy(1), 1'b0);
    chk("rst_wait_rdata", rdat(1), 8'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    clear_model(1);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    rst_b = 1'b0;
    @(posedge PCLK); #1;
    xfer(1, 1'b0, 4'd4, 8'h00);
    xfer(1, 1'b1, 4'd4, 8'h5A);
    xfer(1, 1'b0, 4'd4, 8'h00);

    // randomized traffic against the reference model
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 7) == 0)
          abort(d, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 11)), 8'($urandom),
                (d == 0) ? 0 : int'($urandom_range(0, 2)));
        xfer(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom));
        if ($urandom_range(0, 3) == 0) idle(d, 1);
      end
      for (int a = 0; a < 16; a++) xfer(d, 1'b0, 4'(a), 8'h00);
      idle(d, 2);
    end

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
